// File: rtl/fx_master.sv
// rtl/fx_master.sv - byte-stream command parser driving single fx_wr/fx_rd strobes on the fx register bus
module fx_master #(
    parameter logic [15:0] TIMEOUT  = 16'd50000,
    parameter bit          WR_ACK   = 1'b1,
    parameter logic [7:0]  ACK_BYTE = 8'h06
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [21:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_opcode
);

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [3:0] {
        IDLE, ADR2, ADR1, ADR0, DATA, WRITE, READ, RCAP, RESP
    } state_t;

    state_t      state, state_nx;
    logic        wr_flag;
    logic [21:0] addr;
    logic [7:0]  data_r;
    logic [7:0]  resp;
    logic [15:0] cnt;
    logic        err_to_r, err_op_r;
    logic        accept, waiting, to_hit, bad_op, good_op;

    assign waiting  = (state == ADR2) || (state == ADR1) || (state == ADR0) || (state == DATA);
    assign rx_ready = (state == IDLE) || waiting;
    assign accept   = rx_valid && rx_ready;
    assign good_op  = (rx_data == OP_WR) || (rx_data == OP_RD);
    assign bad_op   = (state == IDLE) && accept && !good_op;
    // A byte arriving on the very cycle the limit is reached still wins over the abort.
    assign to_hit   = (TIMEOUT != 16'd0) && waiting && !accept && (cnt >= TIMEOUT - 16'd1);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && good_op) state_nx = ADR2;
            ADR2:    if (accept) state_nx = ADR1;
            ADR1:    if (accept) state_nx = ADR0;
            ADR0:    if (accept) state_nx = wr_flag ? DATA : READ;
            DATA:    if (accept) state_nx = WRITE;
            WRITE:   state_nx = WR_ACK ? RESP : IDLE;
            READ:    state_nx = RCAP;
            RCAP:    state_nx = RESP;
            RESP:    if (tx_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (to_hit) state_nx = IDLE;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_flag  <= 1'b0;
            addr     <= 22'h0;
            data_r   <= 8'h0;
            resp     <= 8'h0;
            cnt      <= 16'h0;
            err_to_r <= 1'b0;
            err_op_r <= 1'b0;
        end else begin
            err_to_r <= to_hit;
            err_op_r <= bad_op;
            if (accept || !waiting) cnt <= 16'h0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (accept) begin
                case (state)
                    IDLE:    wr_flag      <= (rx_data == OP_WR);
                    ADR2:    addr[21:16]  <= rx_data[5:0];
                    ADR1:    addr[15:8]   <= rx_data;
                    ADR0:    addr[7:0]    <= rx_data;
                    DATA:    data_r       <= rx_data;
                    default: ;
                endcase
            end
            if (state == WRITE && WR_ACK) resp <= ACK_BYTE;
            if (state == RCAP)            resp <= fx_q;
        end
    end

    assign fx_waddr    = addr;
    assign fx_raddr    = addr;
    assign fx_data     = data_r;
    assign fx_wr       = (state == WRITE);
    assign fx_rd       = (state == READ);
    assign tx_data     = resp;
    assign tx_valid    = (state == RESP);
    assign busy        = (state != IDLE);
    assign err_timeout = err_to_r;
    assign err_opcode  = err_op_r;

endmodule

// File: tb/tb_fx_master.sv
// tb/tb_fx_master.sv - directed self-checking bench for fx_master
module tb_fx_master;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [21:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd;
    logic [7:0]  fx_data;
    logic [7:0]  fx_q = 8'h0;
    logic        busy, err_timeout, err_opcode;

    fx_master #(.TIMEOUT(16'd100), .WR_ACK(1'b1), .ACK_BYTE(8'h06)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
        .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
        .busy(busy), .err_timeout(err_timeout), .err_opcode(err_opcode)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_pass = 0, n_total = 0;
    int          wr_cnt = 0, rd_cnt = 0, to_cnt = 0, op_cnt = 0;
    logic [21:0] last_waddr = 22'h0, last_raddr = 22'h0;
    logic [7:0]  last_wdata = 8'h0;
    logic [7:0]  slave_q = 8'h0;
    logic        busy_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave model: OR-bus data valid exactly the cycle after fx_rd, zero otherwise.
    always @(posedge clk_sys) fx_q <= fx_rd ? slave_q : 8'h00;

    always @(posedge clk_sys) begin
        if (fx_wr) begin wr_cnt++; last_waddr = fx_waddr; last_wdata = fx_data; end
        if (fx_rd) begin rd_cnt++; last_raddr = fx_raddr; end
        if (err_timeout) to_cnt++;
        if (err_opcode) op_cnt++;
        if (busy) busy_seen = 1'b1;
        if (fx_wr && fx_rd) chk("strobe_excl", 1, 0);
    end

    task automatic send_byte(input logic [7:0] b);
        logic rdy, ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = rx_ready;
            @(posedge clk_sys);
            ok = rdy;
            @(negedge clk_sys);
        end
        chk("rx_accept", ok, 1);
    endtask

    task automatic get_tx(input logic [7:0] exp, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (tx_valid) seen = 1'b1;
            else @(negedge clk_sys);
        end
        chk({tag, "_valid"}, seen, 1);
        chk({tag, "_data"}, tx_data, exp);
        tx_ready = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        tx_ready = 1'b0;
    endtask

    int w0, r0, t0, o0;
    logic hold_ok;

    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", fx_waddr, 0);
        chk("rst_raddr", fx_raddr, 0);
        chk("rst_strobes", {fx_wr, fx_rd, err_timeout, err_opcode}, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // T1 write
        w0 = wr_cnt;
        send_byte(8'h57); send_byte(8'h05); send_byte(8'h00); send_byte(8'h81); send_byte(8'hA5);
        rx_valid = 1'b0;
        get_tx(8'h06, "t1_tx");
        chk("t1_wr_count", wr_cnt - w0, 1);
        chk("t1_waddr", last_waddr, 22'h050081);
        chk("t1_wdata", last_wdata, 8'hA5);
        chk("t1_idle", busy, 0);

        // T2 read
        slave_q = 8'h3C;
        w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h52); send_byte(8'h05); send_byte(8'h00); send_byte(8'h10);
        rx_valid = 1'b0;
        get_tx(8'h3C, "t2_tx");
        chk("t2_rd_count", rd_cnt - r0, 1);
        chk("t2_wr_count", wr_cnt - w0, 0);
        chk("t2_raddr", last_raddr, 22'h050010);
        chk("t2_waddr_shared", fx_waddr, 22'h050010);

        // T3 read with stalled sink; A2[7:6] set and must be ignored
        slave_q = 8'h3C;
        send_byte(8'hD2 & 8'h52 | 8'h00); send_byte(8'hC5); send_byte(8'h00); send_byte(8'h10);
        rx_valid = 1'b0;
        for (int i = 0; i < 10 && !tx_valid; i++) @(negedge clk_sys);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(tx_valid && tx_data == 8'h3C && !rx_ready)) hold_ok = 1'b0;
            @(negedge clk_sys);
        end
        chk("t3_hold", hold_ok, 1);
        chk("t3_raddr", last_raddr, 22'h050010);
        get_tx(8'h3C, "t3_tx");
        chk("t3_idle_after_hs", busy, 0);

        // T4 timeout after two bytes, boundary just before the limit
        w0 = wr_cnt; t0 = to_cnt;
        send_byte(8'h57); send_byte(8'h05);
        rx_valid = 1'b0;
        repeat (95) @(negedge clk_sys);
        chk("t4_not_yet", {busy, 8'(to_cnt - t0)}, {1'b1, 8'd0});
        repeat (10) @(negedge clk_sys);
        chk("t4_timeout", to_cnt - t0, 1);
        chk("t4_no_wr", wr_cnt - w0, 0);
        chk("t4_idle", busy, 0);
        slave_q = 8'h3C; r0 = rd_cnt;
        send_byte(8'h52); send_byte(8'h05); send_byte(8'h00); send_byte(8'h10);
        rx_valid = 1'b0;
        get_tx(8'h3C, "t4_tx");
        chk("t4_rd_count", rd_cnt - r0, 1);

        // T5 bad opcodes
        w0 = wr_cnt; r0 = rd_cnt; o0 = op_cnt; busy_seen = 1'b0;
        send_byte(8'h00); send_byte(8'hFF);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("t5_opcode", op_cnt - o0, 2);
        chk("t5_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("t5_busy", busy_seen, 0);

        // T6 reset mid-frame, rx_valid held throughout
        w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h57); send_byte(8'h05); send_byte(8'h00);
        rx_data = 8'hA5;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("t6_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("t6_rst_busy", busy, 0);
        rst_n = 1'b1;
        send_byte(8'h57); send_byte(8'h05); send_byte(8'h00); send_byte(8'h81); send_byte(8'hA5);
        rx_valid = 1'b0;
        get_tx(8'h06, "t6_tx");
        chk("t6_wr_count", wr_cnt - w0, 1);
        chk("t6_waddr", last_waddr, 22'h050081);
        chk("t6_wdata", last_wdata, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
